div_unit: RTL and testbench

Multi-cycle iterative radix-2 integer divider for the MIPS EX stage. It executes DIV and DIVU and returns {HI, LO} = {remainder, quotient}. It drives the `div_ready` input of the hazard unit, which holds `stallE` while a divide is in EX and `div_ready` is low. It also accepts an annul from pipeline flushes.

---
 rtl/div_if.sv | 27 ++
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_if : request/result bundle between the EX stage and div_unit      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface div_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit : iterative radix-2 restoring divider, DIV/DIVU, {rem, quo}  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_trial;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_neg_a = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign w_neg_b = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign w_abs_a = w_neg_a ? ({WIDTH{1'b0}} - bus.opdata1_i) : bus.opdata1_i;
  assign w_abs_b = w_neg_b ? ({WIDTH{1'b0}} - bus.opdata2_i) : bus.opdata2_i;

  // Partial remainder stays below the divisor, so its low WIDTH bits suffice
  // before the shift; the extra trial bit is the borrow.
  assign w_shift    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, dvsr_q};
  assign w_ge       = ~w_trial[WIDTH+1];
  assign w_rem_next = w_ge ? w_trial[WIDTH:0] : w_shift;
  assign w_quo_next = {quo_q[WIDTH-2:0], w_ge};

  assign w_quo_fix = (signed_q & (sign1_q ^ sign2_q)) ?
                     ({WIDTH{1'b0}} - w_quo_next) : w_quo_next;
  assign w_rem_fix = (signed_q & sign1_q) ?
                     ({WIDTH{1'b0}} - w_rem_next[WIDTH-1:0]) : w_rem_next[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    signed_d = signed_q;
    result_d = result_q;
    ready_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d  = S_ON;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = w_abs_a;
            dvsr_d   = w_abs_b;
            sign1_d  = bus.opdata1_i[WIDTH-1];
            sign2_d  = bus.opdata2_i[WIDTH-1];
            signed_d = bus.signed_i;
          end
        end
      end
      S_BYZERO: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = w_rem_next;
          quo_d = w_quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = S_END;
            result_d = {w_rem_fix, w_quo_fix};
            ready_d  = 1'b1;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      signed_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      signed_q <= signed_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_unit : directed vector bench for div_unit                      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_div_unit;

  logic clk;
  logic rst;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_total;
  int n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res);
    bus.start_i   = 1'b1;
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    lat = -1;
    res = '0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) begin
        lat = c;
        res = bus.result_o;
        break;
      end
    end
    bus.start_i = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic [63:0] prev;
    logic        saw;
    int          npulse;
    int          pcyc [2];
    logic [63:0] pres [2];

    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 33};
    vecs[5]  = '{1'b0, 32'h00001234,   32'h00000000,   64'h00000000_00000000, 2};
    vecs[6]  = '{1'b1, 32'h00001234,   32'h00000000,   64'h00000000_00000000, 2};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   64'h0000000F_0FFFFFFF, 33};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33};
    vecs[9]  = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 33};
    vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   64'h00000001_00000001, 33};

    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    #1;
    chk("reset_ready",  {63'd0, bus.ready_o}, 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, res);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready_pulse", i), {63'd0, bus.ready_o}, 64'd0);
    end

    // Annul at cycle 10 of a running divide.
    prev = bus.result_o;
    saw  = 1'b0;
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) saw = 1'b1;
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ready_o) saw = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("annul_no_ready", {63'd0, saw}, 64'd0);
    chk("annul_result_held", bus.result_o, prev);
    do_div(1'b0, 32'd9, 32'd3, lat, res);
    chk("post_annul_latency", 64'(lat), 64'd33);
    chk("post_annul_result", res, 64'h00000000_00000003);
    @(posedge clk);
    #1;

    // Back-to-back with start held high throughout.
    npulse = 0;
    pcyc[0] = -1; pcyc[1] = -1;
    pres[0] = '0; pres[1] = '0;
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd20;
    bus.opdata2_i = 32'd6;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) begin
        if (npulse < 2) begin
          pcyc[npulse] = c;
          pres[npulse] = bus.result_o;
        end
        npulse++;
      end
      if (c == 33) begin
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
      end
    end
    bus.start_i = 1'b0;
    chk("b2b_pulse_count", 64'(npulse), 64'd2);
    chk("b2b_first_cycle", 64'(pcyc[0]), 64'd33);
    chk("b2b_first_result", pres[0], 64'h00000002_00000003);
    chk("b2b_second_cycle", 64'(pcyc[1]), 64'd67);
    chk("b2b_second_result", pres[1], 64'h00000000_0000000A);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a divide.
    saw = 1'b0;
    bus.start_i   = 1'b1;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) saw = 1'b1;
    end
    rst = 1'b1;
    bus.start_i = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) saw = 1'b1;
    end
    chk("midrst_no_ready", {63'd0, saw}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
